// File: rtl/dot_prod_pkg.sv
// Shared types and helpers for the two-term carry-save dot-product generator.
// Holds the controller state encoding, the default operand width with its
// derived bit-index width, and the gated/shifted partial-product helper.
package dot_prod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default operand width and the width of a bit index into one operand.
  localparam int DP_BW    = 8;
  localparam int DP_IDX_W = $clog2(DP_BW);

  // Partial products are formed at a fixed generous width and truncated by
  // the caller to 2*BW, which keeps the helper independent of BW.
  localparam int PP_MAX_W = 64;

  // One row of the shift-and-add multiplication: the multiplicand shifted
  // to bit position sh, or zero when the multiplier bit is clear.
  function automatic logic [PP_MAX_W-1:0] gated_pp(
    input logic                sel,
    input logic [PP_MAX_W-1:0] mcand,
    input int unsigned         sh
  );
    return sel ? (mcand << sh) : '0;
  endfunction

endpackage

// File: rtl/csa_4to2.sv
// 4:2 carry-save compressor built from two cascaded 3:2 stages.
// sum_o + carry_o == in0_i + in1_i + in2_i + in3_i (mod 2^W). Each stage's
// carry vector is shifted left one place and its top bit dropped, so
// carry_o[0] is always 0. Purely combinational.
module csa_4to2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  input  logic [W-1:0] in2_i,
  input  logic [W-1:0] in3_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-2:0] c1_raw;
  logic [W-2:0] c2_raw;
  logic [W-1:0] c1;

  // Only the lower W-1 majority bits survive the left shift.
  for (genvar gi = 0; gi < W; gi++) begin : g_xor
    assign s1[gi] = in0_i[gi] ^ in1_i[gi] ^ in2_i[gi];
    assign s2[gi] = s1[gi] ^ c1[gi] ^ in3_i[gi];
  end

  for (genvar gi = 0; gi < W - 1; gi++) begin : g_maj
    assign c1_raw[gi] = (in0_i[gi] & in1_i[gi]) | (in0_i[gi] & in2_i[gi]) |
                        (in1_i[gi] & in2_i[gi]);
    assign c2_raw[gi] = (s1[gi] & c1[gi]) | (s1[gi] & in3_i[gi]) |
                        (c1[gi] & in3_i[gi]);
  end

  assign c1      = {c1_raw, 1'b0};
  assign sum_o   = s2;
  assign carry_o = {c2_raw, 1'b0};

endmodule

// File: rtl/dot_prod_two_cs_gen.sv
// Sequential carry-save producer of a*b + c*d (mod 2^(2*BW)).
// One multiplier bit of a and of c is retired per RUN cycle through a 4:2
// compressor; the final carry-propagate add is left to the consumer.
// Optional build macro DOT_PROD_TWO_EARLY_TERM_EN: leave RUN as soon as no
// set bits remain above the current index in a|c (results are identical,
// only latency changes).
module dot_prod_two_cs_gen
  import dot_prod_pkg::*;
#(
  parameter int BW = DP_BW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   a,
  input  logic [BW-1:0]   b,
  input  logic [BW-1:0]   c,
  input  logic [BW-1:0]   d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*BW-1:0] comp_0,
  output logic [2*BW-1:0] comp_1
);

  localparam int PW    = 2 * BW;
  localparam int IDX_W = $clog2(BW);

  state_e           state_q;
  logic [BW-1:0]    a_q, b_q, c_q, d_q;
  logic [PW-1:0]    sum_q, carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [PP_MAX_W-1:0] pp_ab_full, pp_cd_full;
  logic [PW-1:0]       pp_ab, pp_cd, sum_d, carry_d;
  logic                last_bit;

  assign pp_ab_full = gated_pp(a_q[idx_q], PP_MAX_W'(b_q), 32'(idx_q));
  assign pp_cd_full = gated_pp(c_q[idx_q], PP_MAX_W'(d_q), 32'(idx_q));
  assign pp_ab      = pp_ab_full[PW-1:0];
  assign pp_cd      = pp_cd_full[PW-1:0];

  // Bits above 2*BW are the modular overflow and are intentionally dropped.
  if (PW < PP_MAX_W) begin : g_pp_trunc
    logic unused_pp_hi;
    assign unused_pp_hi = ^{pp_ab_full[PP_MAX_W-1:PW], pp_cd_full[PP_MAX_W-1:PW]};
  end

  csa_4to2 #(.W(PW)) u_csa (
    .in0_i   (sum_q),
    .in1_i   (carry_q),
    .in2_i   (pp_ab),
    .in3_i   (pp_cd),
    .sum_o   (sum_d),
    .carry_o (carry_d)
  );

`ifdef DOT_PROD_TWO_EARLY_TERM_EN
  // Multiplier bits still to be processed after the current index. A zero
  // pair of multipliers terminates after the first RUN cycle with an all-zero
  // result, giving the minimum latency of one.
  logic [BW-1:0] rem_mult;
  assign rem_mult = (a_q | c_q) >> (32'(idx_q) + 32'd1);
  assign last_bit = (idx_q == IDX_W'(BW - 1)) || (rem_mult == '0);
`else
  assign last_bit = (idx_q == IDX_W'(BW - 1));
`endif

  // Controller and datapath registers: accept, iterate one bit per cycle,
  // then hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= c;
            d_q     <= d;
            sum_q   <= '0;
            carry_q <= '0;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_bit) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign comp_0    = sum_q;
  assign comp_1    = carry_q;

endmodule

// File: tb/tb_dot_prod_two_cs_gen.sv
// Directed and randomised checks of dot_prod_two_cs_gen at BW=8.
// Expected latencies follow the DOT_PROD_TWO_EARLY_TERM_EN build selection.
module tb_dot_prod_two_cs_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0, b = '0, c = '0, d = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] comp_0, comp_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_prod_two_cs_gen #(.BW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .comp_0    (comp_0),
    .comp_1    (comp_1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cs_sum();
    return comp_0 + comp_1;
  endfunction

  // Accept one operand set, measure latency and check the carry-save result.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] tc, input logic [7:0] td,
                        input logic [15:0] exp_sum, input int lat_full,
                        input int lat_early, input bit release_out);
    int lat;
    int exp_lat;
    int guard;
`ifdef DOT_PROD_TWO_EARLY_TERM_EN
    exp_lat = lat_early;
`else
    exp_lat = lat_full;
`endif
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check($sformatf("%s in_ready_before_accept", tag), 32'(in_ready), 32'd1);
    a = ta; b = tb_v; c = tc; d = td;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; c = ~tc; d = ~td;
    check($sformatf("%s in_ready_after_accept", tag), 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 64) begin
      step();
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s sum", tag), 32'(cs_sum()), 32'(exp_sum));
    check($sformatf("%s comp_1_lsb", tag), 32'(comp_1[0]), 32'd0);
    check($sformatf("%s in_ready_in_done", tag), 32'(in_ready), 32'd0);
    $display("op %s a=%0d b=%0d c=%0d d=%0d sum=%0d latency=%0d", tag, ta, tb_v, tc, td,
             cs_sum(), lat);
    if (release_out) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("%s out_valid_after_take", tag), 32'(out_valid), 32'd0);
      check($sformatf("%s in_ready_after_take", tag), 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] c0_cap, c1_cap;
    int guard;

    // Reset state
    rst = 1'b1;
    step(); step();
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset comp_0", 32'(comp_0), 32'd0);
    check("reset comp_1", 32'(comp_1), 32'd0);
    // rst wins over a simultaneous in_valid
    in_valid = 1'b1; a = 8'd5; b = 8'd5; c = 8'd5; d = 8'd5;
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    check("post_reset in_ready", 32'(in_ready), 32'd1);
    check("post_reset out_valid", 32'(out_valid), 32'd0);

    // Directed vectors
    run_op("small", 8'd3, 8'd5, 8'd7, 8'd11, 16'd92, 8, 3, 1'b1);
    run_op("max", 8'd255, 8'd255, 8'd255, 8'd255, 16'd64514, 8, 8, 1'b1);
    run_op("zero_mult", 8'd0, 8'd200, 8'd0, 8'd200, 16'd0, 8, 1, 1'b1);
    run_op("msb_only", 8'd128, 8'd255, 8'd0, 8'd0, 16'd32640, 8, 8, 1'b1);

    // Backpressure: result held for 20 cycles with garbage on the input side
    run_op("bp", 8'd9, 8'd10, 8'd6, 8'd7, 16'd132, 8, 4, 1'b0);
    c0_cap = comp_0;
    c1_cap = comp_1;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("bp out_valid_held", 32'(out_valid), 32'd1);
      check("bp in_ready_low", 32'(in_ready), 32'd0);
      check("bp comp_0_stable", 32'(comp_0), 32'(c0_cap));
      check("bp comp_1_stable", 32'(comp_1), 32'(c1_cap));
    end
    check("bp sum_held", 32'(cs_sum()), 32'd132);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    run_op("ones", 8'd1, 8'd1, 8'd1, 8'd1, 16'd2, 8, 1, 1'b1);

    // Reset on the 4th RUN cycle aborts the operation
    a = 8'd128; b = 8'd2; c = 8'd1; d = 8'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort comp_0", 32'(comp_0), 32'd0);
    check("abort comp_1", 32'(comp_1), 32'd0);
    check("abort in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    check("abort in_ready_after", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      check("abort no_out_valid", 32'(out_valid), 32'd0);
    end
    $display("op abort a=128 b=2 c=1 d=1 result discarded");
    run_op("after_abort", 8'd128, 8'd2, 8'd0, 8'd0, 16'd256, 8, 8, 1'b1);

    // Random operands with random handshake timing
    for (int n = 0; n < 300; n++) begin
      logic [7:0]  ra, rb, rc, rd;
      logic [15:0] exp_v;
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rc = '0;
      exp_v = 16'(32'(ra) * 32'(rb) + 32'(rc) * 32'(rd));
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
      a = ra; b = rb; c = rc; d = rd;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        step();
        guard++;
      end
      step();
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      guard = 0;
      while (!out_valid && guard < 64) begin
        in_valid = 1'($urandom_range(0, 1));
        step();
        guard++;
      end
      check($sformatf("rand%0d sum", n), 32'(cs_sum()), 32'(exp_v));
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b0;
      check($sformatf("rand%0d single_emit", n), 32'(out_valid), 32'd0);
      $display("op rand%0d a=%0d b=%0d c=%0d d=%0d expected=%0d", n, ra, rb, rc, rd, exp_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
